// File: rtl/minibus_pkg.sv
// Shared minibus payload types and the arbiter state encoding.
package minibus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } minibus_req_t;

  typedef struct packed {
    logic              ready;
    logic              error;
    logic [DATA_W-1:0] rdata;
  } minibus_res_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/minibus_arbiter_if.sv
// Bundle of the per-master request/response ports, the shared decoder port and arbiter status.
interface minibus_arbiter_if #(
  parameter int unsigned N_MASTERS = 4
);
  import minibus_pkg::*;

  minibus_req_t         m_req [N_MASTERS];
  minibus_res_t         m_res [N_MASTERS];
  minibus_req_t         s_req;
  minibus_res_t         s_res;
  logic [N_MASTERS-1:0] grant;
  logic                 busy;

  // Requesters and the decoder side drive the bus.
  modport master (
    output m_req, s_res,
    input  m_res, s_req, grant, busy
  );

  // The arbiter itself.
  modport slave (
    input  m_req, s_res,
    output m_res, s_req, grant, busy
  );

endinterface

// File: rtl/minibus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_picker #(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             valid
);

  localparam int unsigned SUM_W = PTR_W + 1;

  logic [SUM_W-1:0] pos;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    pos    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + SUM_W'(k);
      if (pos >= SUM_W'(N)) begin
        pos = pos - SUM_W'(N);
      end
      idx = pos[PTR_W-1:0];
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/minibus_arbiter.sv
// Round-robin arbiter sharing one minibus port between N_MASTERS requesters,
// holding each grant until completion, abort or timeout.
module minibus_arbiter #(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic              CLK,
  input logic              nRST,
  minibus_arbiter_if.slave bus
);
  import minibus_pkg::*;

  localparam int unsigned PTR_W      = $clog2(N_MASTERS);
  localparam int unsigned TIMER_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TIMER_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  arb_state_t           state;
  logic [N_MASTERS-1:0] grant_q;
  logic                 busy_q;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     g_idx;
  logic [TIMER_W-1:0]   timer;

  logic [N_MASTERS-1:0] req_vec;
  logic [N_MASTERS-1:0] winner;
  logic                 pick_valid;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     next_ptr;
  logic                 g_active;
  logic                 expire;
  logic                 finish;

  always_comb begin
    req_vec = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      req_vec[i] = bus.m_req[i].ren | bus.m_req[i].wen;
    end
  end

  rr_picker #(
    .N (N_MASTERS)
  ) u_picker (
    .req    (req_vec),
    .ptr    (rr_ptr),
    .winner (winner),
    .valid  (pick_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (winner[i]) begin
        win_idx = PTR_W'(i);
      end
    end
  end

  // Transaction end conditions; a slave ready in the expiry cycle beats the timeout.
  always_comb begin
    g_active = req_vec[g_idx];
    expire   = TIMEOUT_EN && (state == ARB_BUSY) && g_active && !bus.s_res.ready &&
               (timer == TIMER_W'(TIMER_LAST));
    finish   = (state == ARB_BUSY) && (bus.s_res.ready || expire || !g_active);
    next_ptr = (g_idx == PTR_W'(N_MASTERS - 1)) ? '0 : g_idx + PTR_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= ARB_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      rr_ptr  <= '0;
      g_idx   <= '0;
      timer   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state   <= ARB_BUSY;
            grant_q <= winner;
            busy_q  <= 1'b1;
            g_idx   <= win_idx;
            timer   <= '0;
          end
        end
        ARB_BUSY: begin
          if (finish) begin
            state   <= ARB_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            rr_ptr  <= next_ptr;
            timer   <= '0;
          end else if (timer != '1) begin
            timer <= timer + TIMER_W'(1);
          end
        end
        default: begin
          state   <= ARB_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Request/response steering; everything is zero outside BUSY.
  always_comb begin
    bus.s_req = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      bus.m_res[i] = '0;
    end
    if (state == ARB_BUSY) begin
      if (expire) begin
        bus.m_res[g_idx].ready = 1'b1;
        bus.m_res[g_idx].error = 1'b1;
      end else begin
        bus.s_req        = bus.m_req[g_idx];
        bus.m_res[g_idx] = bus.s_res;
      end
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;

  grant_onehot_a : assert property (@(posedge CLK) disable iff (!nRST)
    $onehot0(grant_q) && (busy_q == (|grant_q)));

endmodule

// File: tb/tb_minibus_arbiter.sv
// Randomised scoreboard bench for minibus_arbiter against a transaction-level reference model.
module tb_minibus_arbiter;
  import minibus_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned T = 8;

  logic CLK;
  logic nRST;

  minibus_arbiter_if #(.N_MASTERS(N)) bus ();

  minibus_arbiter #(
    .N_MASTERS      (N),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned id;
    logic        err;
    logic [31:0] rdata;
  } exp_res_t;

  exp_res_t     res_q [$];
  minibus_req_t sreq_q [$];
  int           checks;
  int           errors;

  // Reference model: which master owns the bus this cycle and how long the slave takes.
  bit           mb;
  bit           ended;
  bit           aborted;
  int unsigned  mg;
  int unsigned  mcnt;
  int unsigned  lat;
  int unsigned  mptr;
  bit           req_on  [N];
  minibus_req_t cur_req [N];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit any_req();
    for (int unsigned i = 0; i < N; i++) if (req_on[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int unsigned pick_rr();
    for (int unsigned k = 0; k < N; k++) begin
      if (req_on[(mptr + k) % N]) return (mptr + k) % N;
    end
    return 0;
  endfunction

  function automatic int unsigned choose_lat();
    int unsigned r;
    r = $urandom_range(9, 0);
    if (r < 5) return $urandom_range(2, 0);
    if (r < 7) return T - 1;
    if (r < 8) return $urandom_range(T - 2, 3);
    return $urandom_range(T + 2, T);
  endfunction

  task automatic new_request(input int unsigned i);
    minibus_req_t r;
    r.ren   = 1'($urandom_range(1, 0));
    r.wen   = !r.ren;
    r.addr  = {4'(i), 28'($urandom)};
    r.wdata = $urandom;
    cur_req[i]   = r;
    req_on[i]    = 1'b1;
    bus.m_req[i] = r;
  endtask

  task automatic drop_request(input int unsigned i);
    req_on[i]    = 1'b0;
    bus.m_req[i] = '0;
  endtask

  // One cycle of stimulus, called just after the rising edge.
  task automatic step(input int unsigned req_pct);
    logic [31:0] rd;
    bit          tmo;
    tmo = 1'b0;
    if (mb) begin
      if (ended) begin
        mb   = 1'b0;
        mptr = (mg + 1) % N;
        if (!aborted) drop_request(mg);
      end else begin
        mcnt++;
      end
    end else if (any_req()) begin
      mg   = pick_rr();
      mb   = 1'b1;
      mcnt = 0;
      lat  = choose_lat();
    end
    ended   = 1'b0;
    aborted = 1'b0;
    if (mb && mcnt > 0 && mcnt != lat && $urandom_range(19, 0) == 0) begin
      drop_request(mg);
      ended   = 1'b1;
      aborted = 1'b1;
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!req_on[i] && !(aborted && i == mg) && $urandom_range(99, 0) < req_pct) new_request(i);
    end
    rd              = $urandom;
    bus.s_res.rdata = rd;
    bus.s_res.error = 1'($urandom_range(1, 0));
    bus.s_res.ready = 1'($urandom_range(1, 0));
    if (mb) begin
      bus.s_res.ready = 1'b0;
      if (!aborted) begin
        tmo = (mcnt == T - 1) && (mcnt != lat);
        if (mcnt == lat) begin
          bus.s_res.ready = 1'b1;
          bus.s_res.error = ($urandom_range(7, 0) == 0);
          res_q.push_back('{id: mg, err: bus.s_res.error, rdata: rd});
          ended = 1'b1;
        end else if (tmo) begin
          res_q.push_back('{id: mg, err: 1'b1, rdata: 32'h0});
          ended = 1'b1;
        end
        if (!tmo) sreq_q.push_back(cur_req[mg]);
      end
    end
  endtask

  // Monitor: per-cycle grant/busy against the model, responses and forwarded requests via queues.
  always @(negedge CLK) begin
    exp_res_t     e;
    minibus_req_t s;
    check("grant", 72'(bus.grant), mb ? (72'(1) << mg) : 72'(0));
    check("busy", 72'(bus.busy), 72'(mb));
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.m_res[i].ready) begin
        if (res_q.size() == 0) begin
          check("resp_unexpected", 72'(bus.m_res[i].ready), 72'(0));
        end else begin
          e = res_q.pop_front();
          check("resp_master", 72'(i), 72'(e.id));
          check("resp_error", 72'(bus.m_res[i].error), 72'(e.err));
          check("resp_rdata", 72'(bus.m_res[i].rdata), 72'(e.rdata));
        end
      end else if (!(mb && i == mg)) begin
        check("ungranted_mres", 72'(bus.m_res[i]), 72'(0));
      end
    end
    if (bus.s_req.ren || bus.s_req.wen) begin
      if (sreq_q.size() == 0) begin
        check("sreq_unexpected", 72'(bus.s_req), 72'(0));
      end else begin
        s = sreq_q.pop_front();
        check("s_req", 72'(bus.s_req), 72'(s));
      end
    end
  end

  initial begin
    int unsigned waited;
    checks  = 0;
    errors  = 0;
    mb      = 1'b0;
    ended   = 1'b0;
    aborted = 1'b0;
    mg      = 0;
    mcnt    = 0;
    lat     = 0;
    mptr    = 0;
    nRST    = 1'b0;
    bus.s_res = '0;
    for (int unsigned i = 0; i < N; i++) drop_request(i);

    repeat (2) @(posedge CLK);
    #1;
    check("reset_grant", 72'(bus.grant), 72'(0));
    check("reset_busy", 72'(bus.busy), 72'(0));
    check("reset_s_req", 72'(bus.s_req), 72'(0));
    @(negedge CLK);
    nRST = 1'b1;

    // Heavy contention, then sparse traffic.
    repeat (1500) begin @(posedge CLK); #1; step(80); end
    repeat (1500) begin @(posedge CLK); #1; step(15); end

    // Reset in the middle of a transaction.
    waited = 0;
    do begin
      @(posedge CLK); #1; step(60);
      waited++;
    end while (!(mb && !ended) && waited < 100);
    if (!(mb && !ended)) begin
      checks++;
      errors++;
      $display("FAIL reset_setup_timeout waited=%0d required=<100", waited);
    end
    @(negedge CLK);
    #2;
    bus.s_res = '{ready: 1'b1, error: 1'b1, rdata: 32'hDEAD_BEEF};
    nRST  = 1'b0;
    mb    = 1'b0;
    ended = 1'b0;
    mptr  = 0;
    #1;
    check("midrst_grant", 72'(bus.grant), 72'(0));
    check("midrst_busy", 72'(bus.busy), 72'(0));
    check("midrst_s_req", 72'(bus.s_req), 72'(0));
    for (int unsigned i = 0; i < N; i++) check("midrst_m_res", 72'(bus.m_res[i]), 72'(0));
    for (int unsigned i = 0; i < N; i++) if (!req_on[i]) new_request(i);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (300) begin @(posedge CLK); #1; step(50); end

    // Drain with no new requests.
    waited = 0;
    do begin
      @(posedge CLK); #1; step(0);
      waited++;
    end while ((mb || any_req()) && waited < 400);
    @(posedge CLK); #1; step(0);
    @(negedge CLK); #1;
    check("drain_pending_resp", 72'(res_q.size()), 72'(0));
    check("drain_pending_sreq", 72'(sreq_q.size()), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
